// File: rtl/pc_profiler_pkg.sv
// Shared definitions for the PC function profiler: register map, control and
// status bit positions, channel state type and saturating helpers.
package pc_profiler_pkg;

  // Word offsets (addr_i[4:2]) inside one channel's 32-byte register window.
  localparam logic [2:0] START_OFF  = 3'd0;
  localparam logic [2:0] END_OFF    = 3'd1;
  localparam logic [2:0] CTRL_OFF   = 3'd2;
  localparam logic [2:0] CALLS_OFF  = 3'd3;
  localparam logic [2:0] TOTAL_OFF  = 3'd4;
  localparam logic [2:0] MAX_OFF    = 3'd5;
  localparam logic [2:0] LAST_OFF   = 3'd6;
  localparam logic [2:0] STATUS_OFF = 3'd7;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_CLR_BIT    = 1;
  localparam int STAT_ACTIVE_BIT = 0;
  localparam int STAT_SAT_BIT    = 1;

  typedef enum logic {ChIdle, ChActive} ch_state_e;

  // Statistics of one channel. Values are clamped to the counter width, so the
  // bits above CntWidth stay zero and reads come out zero-extended.
  typedef struct packed {
    logic [31:0] calls;
    logic [31:0] total;
    logic [31:0] max_cyc;
    logic [31:0] last;
  } ch_stats_t;

  typedef struct packed {
    logic [31:0] value;
    logic        sat;
  } sat_res_t;

  // a + b clamped to max_val; sat flags that clamping happened.
  function automatic sat_res_t sat_add(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] max_val);
    sat_res_t    res;
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) begin
      res.value = max_val;
      res.sat   = 1'b1;
    end else begin
      res.value = sum[31:0];
      res.sat   = 1'b0;
    end
    return res;
  endfunction

  // Byte-enable merge of a bus write into an existing register value.
  function automatic logic [31:0] merge_be(input logic [31:0] old_val, input logic [31:0] new_val,
                                           input logic [3:0] be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pc_profiler_channel.sv
// One profiler channel: START/END/CTRL registers, IDLE/ACTIVE tracker and the
// saturating call statistics.
module pc_profiler_channel
  import pc_profiler_pkg::*;
#(
  parameter int CntWidth = 32,
  parameter int PcWidth  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PcWidth-1:0] pc,
  input  logic               pc_valid,
  input  logic               wr,
  input  logic [2:0]         off,
  input  logic [3:0]         be,
  input  logic [31:0]        wdata,
  output logic [31:0]        rd_word,
  output logic               active
);

  localparam logic [31:0] CntMax = 32'((64'd1 << CntWidth) - 64'd1);

  ch_state_e          state_q;
  logic [PcWidth-1:0] start_q, end_q;
  logic               en_q, sat_q;
  ch_stats_t          stats_q;
  logic [31:0]        elapsed_q;

  logic               wr_start, wr_end, wr_ctrl, clear, en_next, abort;
  logic               start_hit, end_hit;
  logic [PcWidth-1:0] start_wr, end_wr;
  sat_res_t           elapsed_inc, calls_inc, total_add;
  logic [31:0]        max_next;

  assign active = (state_q == ChActive);

  // Decode this cycle's write and form every candidate update up front.
  // NOTE: every signal gets a value on every path here, so no latch is inferred.
  always_comb begin
    wr_start    = wr && (off == START_OFF);
    wr_end      = wr && (off == END_OFF);
    wr_ctrl     = wr && (off == CTRL_OFF);
    clear       = wr_ctrl && be[0] && wdata[CTRL_CLR_BIT];
    en_next     = (wr_ctrl && be[0]) ? wdata[CTRL_EN_BIT] : en_q;
    abort       = (state_q == ChActive) && (wr_start || wr_end || !en_next);
    start_hit   = pc_valid && (pc == start_q);
    end_hit     = pc_valid && (pc == end_q);
    start_wr    = PcWidth'(merge_be(32'(start_q), wdata, be));
    end_wr      = PcWidth'(merge_be(32'(end_q), wdata, be));
    // elapsed+1 is both the next ACTIVE count and the length of a call ending now.
    elapsed_inc = sat_add(elapsed_q, 32'd1, CntMax);
    calls_inc   = sat_add(stats_q.calls, 32'd1, CntMax);
    total_add   = sat_add(stats_q.total, elapsed_inc.value, CntMax);
    max_next    = (elapsed_inc.value > stats_q.max_cyc) ? elapsed_inc.value : stats_q.max_cyc;
  end

  // Registers, FSM and statistics; clear beats abort, abort beats a PC match.
  // NOTE: state is updated only with non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ChIdle;
      start_q   <= '0;
      end_q     <= '0;
      en_q      <= 1'b0;
      sat_q     <= 1'b0;
      stats_q   <= '0;
      elapsed_q <= '0;
    end else begin
      if (wr_start) start_q <= start_wr;
      if (wr_end)   end_q   <= end_wr;
      en_q <= en_next;
      if (clear) begin
        state_q   <= ChIdle;
        stats_q   <= '0;
        sat_q     <= 1'b0;
        elapsed_q <= '0;
      end else if (abort) begin
        state_q <= ChIdle;
      end else if (en_q) begin
        case (state_q)
          ChIdle: begin
            if (start_hit) begin
              if (end_hit) begin
                stats_q.calls <= calls_inc.value;
                stats_q.last  <= '0;
                sat_q         <= sat_q | calls_inc.sat;
              end else begin
                state_q   <= ChActive;
                elapsed_q <= '0;
              end
            end
          end
          ChActive: begin
            if (end_hit) begin
              state_q         <= ChIdle;
              stats_q.calls   <= calls_inc.value;
              stats_q.total   <= total_add.value;
              stats_q.last    <= elapsed_inc.value;
              stats_q.max_cyc <= max_next;
              sat_q <= sat_q | elapsed_inc.sat | calls_inc.sat | total_add.sat;
            end else begin
              elapsed_q <= elapsed_inc.value;
              sat_q     <= sat_q | elapsed_inc.sat;
            end
          end
          default: state_q <= ChIdle;
        endcase
      end
    end
  end

  // Present the register selected by the word offset to the top-level read mux.
  always_comb begin
    rd_word = '0;
    case (off)
      START_OFF:  rd_word = 32'(start_q);
      END_OFF:    rd_word = 32'(end_q);
      CTRL_OFF:   rd_word[CTRL_EN_BIT] = en_q;
      CALLS_OFF:  rd_word = stats_q.calls;
      TOTAL_OFF:  rd_word = stats_q.total;
      MAX_OFF:    rd_word = stats_q.max_cyc;
      LAST_OFF:   rd_word = stats_q.last;
      STATUS_OFF: begin
        rd_word[STAT_ACTIVE_BIT] = active;
        rd_word[STAT_SAT_BIT]    = sat_q;
      end
      default:    rd_word = '0;
    endcase
  end

endmodule

// File: rtl/pc_profiler.sv
// PC function profiler bus device: NumChannels independent start/end address
// channels behind a simple req/we/be/addr/wdata/rvalid/rdata slave port.
module pc_profiler
  import pc_profiler_pkg::*;
#(
  parameter int NumChannels = 4,
  parameter int CntWidth    = 32,
  parameter int PcWidth     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [PcWidth-1:0]     pc_i,
  input  logic                   pc_valid_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [3:0]             be_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wdata_i,
  output logic                   rvalid_o,
  output logic [31:0]            rdata_o,
  output logic [NumChannels-1:0] active_o
);

  localparam int ChIdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  logic [2:0]                        off;
  logic [ChIdxW-1:0]                 ch_idx;
  logic                              mapped;
  logic [NumChannels-1:0][31:0]      ch_word;
  logic [31:0]                       rd_word;
  logic                              unused_addr;

  assign off         = addr_i[4:2];
  assign ch_idx      = addr_i[5 +: ChIdxW];
  assign mapped      = 32'(ch_idx) < 32'(NumChannels);
  assign unused_addr = ^{addr_i[31:5+ChIdxW], addr_i[1:0]};

  for (genvar g = 0; g < NumChannels; g++) begin : g_ch
    pc_profiler_channel #(
      .CntWidth (CntWidth),
      .PcWidth  (PcWidth)
    ) u_ch (
      .clk      (clk_i),
      .rst      (rst_i),
      .pc       (pc_i),
      .pc_valid (pc_valid_i),
      .wr       (req_i && we_i && (ch_idx == ChIdxW'(g))),
      .off      (off),
      .be       (be_i),
      .wdata    (wdata_i),
      .rd_word  (ch_word[g]),
      .active   (active_o[g])
    );
  end

  // Select the addressed channel's word; unmapped channel indices read zero.
  always_comb begin
    rd_word = '0;
    if (mapped) rd_word = ch_word[ch_idx];
  end

  // Single-cycle response: every request, read or write, gets rvalid next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= req_i;
      rdata_o  <= (req_i && !we_i) ? rd_word : '0;
    end
  end

endmodule
